// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a 2-entry {word, pc} queue.
// Issues single outstanding 16-bit reads, queues returned words for decode,
// handles redirects (with stale-response dropping) and stops at HLT (opcode F).
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   stall              - decode not accepting; head instruction held
//   redirect, redirect_pc - flush and refetch from redirect_pc (bit 0 forced 0)
//   mem_req, mem_addr  - one-cycle read request and word-aligned address
//   mem_valid, mem_data - read response strobe and instruction word
//   inst, inst_pc, pc_plus_two, inst_valid - head-of-queue instruction to decode
//   halted             - HLT fetched and queue drained
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_valid,
  input  logic [15:0] mem_data,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic [15:0] pc_plus_two,
  output logic        inst_valid,
  output logic        halted
);

  localparam int unsigned XLEN  = 16;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  word0_q, word0_d, word1_q, word1_d;
  logic [XLEN-1:0]  pc0_q, pc0_d, pc1_q, pc1_d;
  logic             enq, deq;

  // Queue head is always entry 0, so decode outputs come straight from flops.
  assign mem_addr    = fetch_pc_q;
  assign inst        = word0_q;
  assign inst_pc     = pc0_q;
  assign pc_plus_two = pc0_q + XLEN'(2);
  assign inst_valid  = (cnt_q != CNT_W'(0));
  assign halted      = (state_q == HALT) && (cnt_q == CNT_W'(0));

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      word0_q    <= '0;
      word1_q    <= '0;
      pc0_q      <= '0;
      pc1_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      word0_q    <= word0_d;
      word1_q    <= word1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
    end
  end

  // Next-state, request and queue update logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    word0_d    = word0_q;
    word1_d    = word1_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    mem_req    = 1'b0;
    enq        = 1'b0;
    deq        = inst_valid && !stall;

    case (state_q)
      IDLE: begin
        // While a dropped response is still in flight, only wait for it.
        if (drop_q) begin
          if (mem_valid) drop_d = 1'b0;
        end else if (cnt_q != CNT_W'(2)) begin
          mem_req = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_valid) begin
          enq        = 1'b1;
          fetch_pc_d = fetch_pc_q + XLEN'(2);
          state_d    = (mem_data[15:12] == 4'hF) ? HALT : IDLE;
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything; a response still owed gets dropped later.
    if (redirect) begin
      mem_req    = 1'b0;
      enq        = 1'b0;
      deq        = 1'b0;
      state_d    = IDLE;
      fetch_pc_d = redirect_pc & 16'hFFFE;
      drop_d     = ((state_q == WAIT) || drop_q) && !mem_valid;
    end

    if (rst) mem_req = 1'b0;

    if (redirect) begin
      cnt_d = '0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (cnt_q == CNT_W'(0)) begin
            word0_d = mem_data;
            pc0_d   = fetch_pc_q;
          end else begin
            word1_d = mem_data;
            pc1_d   = fetch_pc_q;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
        2'b01: begin
          word0_d = word1_q;
          pc0_d   = pc1_q;
          cnt_d   = cnt_q - CNT_W'(1);
        end
        2'b11: begin
          // Count unchanged; new word lands behind whatever remains.
          if (cnt_q == CNT_W'(1)) begin
            word0_d = mem_data;
            pc0_d   = fetch_pc_q;
          end else begin
            word0_d = word1_q;
            pc0_d   = pc1_q;
            word1_d = mem_data;
            pc1_d   = fetch_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] pc_plus_two;
  logic        inst_valid;
  logic        halted;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  bit hlt_en = 1'b0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_valid   (mem_valid),
    .mem_data    (mem_data),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .pc_plus_two (pc_plus_two),
    .inst_valid  (inst_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_en && a == 16'h000A) return 16'hF000;
    return {4'h2, a[11:0]};
  endfunction

  // Memory: requests seen at negedge, answered lat cycles later at negedge.
  logic [15:0] q_addr[$];
  int          q_due[$];
  int          ncyc = 0;
  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      mem_valid = 1'b0;
      mem_data  = '0;
      if (q_due.size() > 0 && q_due[0] == ncyc) begin
        mem_valid = 1'b1;
        mem_data  = mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (mem_req) begin
        q_addr.push_back(mem_addr);
        q_due.push_back(ncyc + lat);
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset long enough for any in-flight response to drain, then
  // releases it; returns in the first cycle after release, outputs settled.
  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (6) tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_req(input logic [15:0] addr);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req && mem_addr == addr) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk1("wait_req", found, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;

    // Reset values and streaming with 1-cycle memory
    lat = 1;
    rst = 1'b1;
    repeat (4) tick();
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_inst_pc", inst_pc, 16'h0000);
    rst = 1'b0;
    #1;
    chk1("s1_req0", mem_req, 1'b1);
    chk("s1_addr0", mem_addr, 16'h0000);
    tick();
    chk1("s1_wait_noreq", mem_req, 1'b0);
    tick();
    chk1("s1_v0", inst_valid, 1'b1);
    chk("s1_pc0", inst_pc, 16'h0000);
    chk("s1_inst0", inst, 16'h2000);
    chk("s1_p2_0", pc_plus_two, 16'h0002);
    chk1("s1_req2", mem_req, 1'b1);
    chk("s1_addr2", mem_addr, 16'h0002);
    tick();
    chk1("s1_empty", inst_valid, 1'b0);
    chk1("s1_noreq", mem_req, 1'b0);
    tick();
    chk("s1_pc2", inst_pc, 16'h0002);
    chk("s1_p2_2", pc_plus_two, 16'h0004);
    chk("s1_addr4", mem_addr, 16'h0004);
    chk1("s1_req4", mem_req, 1'b1);

    // Stall with 3-cycle memory: queue fills to two, requests stop
    lat = 3;
    stall = 1'b1;
    do_reset();
    chk1("s2_req0", mem_req, 1'b1);
    repeat (4) tick();
    chk1("s2_v0", inst_valid, 1'b1);
    chk("s2_pc0", inst_pc, 16'h0000);
    chk1("s2_req2", mem_req, 1'b1);
    chk("s2_addr2", mem_addr, 16'h0002);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      chk1("s2_full_noreq", mem_req, 1'b0);
      chk("s2_full_pc", inst_pc, 16'h0000);
      tick();
    end
    stall = 1'b0;
    #1;
    tick();
    chk("s2_deq_pc", inst_pc, 16'h0002);
    chk("s2_deq_inst", inst, 16'h2002);
    chk1("s2_resume_req", mem_req, 1'b1);
    chk("s2_resume_addr", mem_addr, 16'h0004);
    tick();
    chk1("s2_drained", inst_valid, 1'b0);

    // Redirect during WAIT drops the stale response
    lat = 1;
    do_reset();
    wait_req(16'h0006);
    lat = 3;
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0041;
    #1;
    chk1("s3_redir_noreq", mem_req, 1'b0);
    tick();
    redirect = 1'b0;
    #1;
    chk1("s3_after_redir_iv", inst_valid, 1'b0);
    chk1("s3_drop_noreq1", mem_req, 1'b0);
    tick();
    chk1("s3_drop_noreq2", mem_req, 1'b0);
    tick();
    chk1("s3_req40", mem_req, 1'b1);
    chk("s3_addr40", mem_addr, 16'h0040);
    chk1("s3_stale_dropped", inst_valid, 1'b0);
    lat = 1;
    repeat (2) tick();
    chk1("s3_v40", inst_valid, 1'b1);
    chk("s3_pc40", inst_pc, 16'h0040);
    chk("s3_inst40", inst, 16'h2040);

    // HLT at 0x000A stops fetching; redirect restarts
    lat = 1;
    hlt_en = 1'b1;
    do_reset();
    wait_req(16'h000A);
    tick();
    chk1("s4_wait_noreq", mem_req, 1'b0);
    tick();
    chk("s4_hlt_inst", inst, 16'hF000);
    chk("s4_hlt_pc", inst_pc, 16'h000A);
    chk1("s4_not_halted_yet", halted, 1'b0);
    chk1("s4_halt_noreq", mem_req, 1'b0);
    tick();
    chk1("s4_halted", halted, 1'b1);
    chk1("s4_halted_iv", inst_valid, 1'b0);
    repeat (3) begin
      tick();
      chk1("s4_halt_stays", halted, 1'b1);
      chk1("s4_halt_noreq2", mem_req, 1'b0);
    end
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    #1;
    chk1("s4_redir_noreq", mem_req, 1'b0);
    tick();
    redirect = 1'b0;
    hlt_en = 1'b0;
    #1;
    chk1("s4_unhalted", halted, 1'b0);
    chk1("s4_restart_req", mem_req, 1'b1);
    chk("s4_restart_addr", mem_addr, 16'h0020);

    // Address wrap at 0xFFFE
    lat = 1;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    #1;
    chk1("s5_redir_noreq", mem_req, 1'b0);
    tick();
    redirect = 1'b0;
    #1;
    chk1("s5_req_fffe", mem_req, 1'b1);
    chk("s5_addr_fffe", mem_addr, 16'hFFFE);
    repeat (2) tick();
    chk("s5_pc_fffe", inst_pc, 16'hFFFE);
    chk("s5_inst_fffe", inst, 16'h2FFE);
    chk("s5_p2_wrap", pc_plus_two, 16'h0000);
    chk1("s5_req_wrap", mem_req, 1'b1);
    chk("s5_addr_wrap", mem_addr, 16'h0000);
    repeat (2) tick();
    chk("s5_pc_0", inst_pc, 16'h0000);
    chk("s5_p2_0", pc_plus_two, 16'h0002);

    // Reset during WAIT; late response arrives while in reset
    lat = 3;
    do_reset();
    chk1("s6_req0", mem_req, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk1("s6_rst_noreq", mem_req, 1'b0);
    chk1("s6_rst_iv", inst_valid, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk1("s6_late_ignored", inst_valid, 1'b0);
    chk1("s6_first_req", mem_req, 1'b1);
    chk("s6_first_addr", mem_addr, 16'h0000);
    tick();
    chk1("s6_still_empty", inst_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
